// File: rtl/ofm_sram_arbiter.sv
// ofm_sram_arbiter: single-port OFM SRAM scheduler for conv writes, line-buffer reads and APB reads.
// Writes queue in a small FIFO; reads that hit a queued address are answered from the newest queued copy.
module ofm_sram_arbiter #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_BITS    = 11,
  parameter int WFIFO_DEPTH  = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                              HCLK,
  input  logic                              HRESET,
  input  logic                              wr_valid,
  output logic                              wr_ready,
  input  logic [ADDR_BITS-1:0]              wr_addr,
  input  logic [DATA_WIDTH-1:0]             wr_data,
  input  logic                              lb_req,
  output logic                              lb_gnt,
  input  logic [ADDR_BITS-1:0]              lb_addr,
  output logic                              lb_rvalid,
  output logic [DATA_WIDTH-1:0]             lb_rdata,
  input  logic                              apb_req,
  output logic                              apb_gnt,
  input  logic [ADDR_BITS-1:0]              apb_addr,
  output logic                              apb_rvalid,
  output logic [DATA_WIDTH-1:0]             apb_rdata,
  output logic                              sram_ce,
  output logic                              sram_we,
  output logic [ADDR_BITS-1:0]              sram_addr,
  output logic [DATA_WIDTH-1:0]             sram_wdata,
  input  logic [DATA_WIDTH-1:0]             sram_rdata,
  output logic [$clog2(WFIFO_DEPTH):0]      wfifo_level,
  output logic                              busy,
  output logic [$clog2(STARVE_LIMIT+1)-1:0] dbg_starve_cnt
);

  localparam int PTR_W = $clog2(WFIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {OWN_NONE, OWN_LB, OWN_APB} owner_t;
  typedef enum logic [1:0] {G_IDLE, G_WRITE, G_LB, G_APB} grant_t;

  // Handshakes: a write transfers on wr_valid && wr_ready; a read request (lb_req/apb_req) and
  // its address are held by the requester until the matching grant is seen in the same cycle.
  logic [ADDR_BITS-1:0]  r_fifo_addr [WFIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_fifo_data [WFIFO_DEPTH];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [LVL_W-1:0]      r_level;
  logic [CNT_W-1:0]      r_starve;
  owner_t                r_owner;
  logic                  r_fwd_hit;
  logic [DATA_WIDTH-1:0] r_fwd_data;

  grant_t                w_grant;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_rd;
  logic                  w_starved;
  logic [ADDR_BITS-1:0]  w_rd_addr;
  logic                  w_fwd_hit;
  logic [DATA_WIDTH-1:0] w_fwd_data;
  logic [DATA_WIDTH-1:0] w_rsp_data;

  assign w_full    = (r_level == LVL_W'(WFIFO_DEPTH));
  assign w_empty   = (r_level == '0);
  assign w_push    = wr_valid && !w_full;
  assign w_starved = apb_req && (r_starve == CNT_W'(STARVE_LIMIT));

  always_comb begin
    w_grant = G_IDLE;
    if (!HRESET) begin
      if (w_full)          w_grant = G_WRITE;
      else if (w_starved)  w_grant = G_APB;
      else if (lb_req)     w_grant = G_LB;
      else if (!w_empty)   w_grant = G_WRITE;
      else if (apb_req)    w_grant = G_APB;
    end
  end

  assign w_pop     = (w_grant == G_WRITE);
  assign w_rd      = (w_grant == G_LB) || (w_grant == G_APB);
  assign w_rd_addr = (w_grant == G_APB) ? apb_addr : lb_addr;

  assign lb_gnt     = (w_grant == G_LB);
  assign apb_gnt    = (w_grant == G_APB);
  assign sram_ce    = (w_grant != G_IDLE);
  assign sram_we    = w_pop;
  assign sram_wdata = w_pop ? r_fifo_data[r_rptr] : '0;

  always_comb begin
    sram_addr = '0;
    if (w_pop)     sram_addr = r_fifo_addr[r_rptr];
    else if (w_rd) sram_addr = w_rd_addr;
  end

  // Oldest-to-newest scan so the last hit is the newest queued write to that address.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    for (int i = 0; i < WFIFO_DEPTH; i++) begin
      if ((LVL_W'(i) < r_level) && !(w_pop && (i == 0)) &&
          (r_fifo_addr[r_rptr + PTR_W'(i)] == w_rd_addr)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_fifo_data[r_rptr + PTR_W'(i)];
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (w_push) begin
      r_fifo_addr[r_wptr] <= wr_addr;
      r_fifo_data[r_wptr] <= wr_data;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_starve   <= '0;
      r_owner    <= OWN_NONE;
      r_fwd_hit  <= 1'b0;
      r_fwd_data <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (!apb_req || apb_gnt)                     r_starve <= '0;
      else if (r_starve != CNT_W'(STARVE_LIMIT))   r_starve <= r_starve + 1'b1;
      case (w_grant)
        G_LB:    r_owner <= OWN_LB;
        G_APB:   r_owner <= OWN_APB;
        default: r_owner <= OWN_NONE;
      endcase
      r_fwd_hit  <= w_rd && w_fwd_hit;
      r_fwd_data <= w_fwd_data;
    end
  end

  assign w_rsp_data = r_fwd_hit ? r_fwd_data : sram_rdata;

  assign lb_rvalid      = (r_owner == OWN_LB);
  assign apb_rvalid     = (r_owner == OWN_APB);
  assign lb_rdata       = lb_rvalid ? w_rsp_data : '0;
  assign apb_rdata      = apb_rvalid ? w_rsp_data : '0;
  assign wr_ready       = !w_full;
  assign wfifo_level    = r_level;
  assign busy           = !w_empty || (r_owner != OWN_NONE);
  assign dbg_starve_cnt = r_starve;

endmodule

// File: tb/tb_ofm_sram_arbiter.sv
// Bench for ofm_sram_arbiter: directed table, multi-cycle sequences and random traffic
// checked every cycle against a queue-based model of the arbiter rules.
module tb_ofm_sram_arbiter;
  localparam int DW    = 8;
  localparam int AW    = 11;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic HCLK = 1'b0;
  logic HRESET;
  always #5 HCLK = ~HCLK;

  logic          wr_valid, wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          lb_req, lb_gnt;
  logic [AW-1:0] lb_addr;
  logic          lb_rvalid;
  logic [DW-1:0] lb_rdata;
  logic          apb_req, apb_gnt;
  logic [AW-1:0] apb_addr;
  logic          apb_rvalid;
  logic [DW-1:0] apb_rdata;
  logic          sram_ce, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata = '0;
  logic [2:0]    wfifo_level;
  logic          busy;
  logic [3:0]    dbg_starve_cnt;

  ofm_sram_arbiter #(
    .DATA_WIDTH(DW), .ADDR_BITS(AW), .WFIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .lb_req(lb_req), .lb_gnt(lb_gnt), .lb_addr(lb_addr), .lb_rvalid(lb_rvalid), .lb_rdata(lb_rdata),
    .apb_req(apb_req), .apb_gnt(apb_gnt), .apb_addr(apb_addr), .apb_rvalid(apb_rvalid),
    .apb_rdata(apb_rdata),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .wfifo_level(wfifo_level), .busy(busy),
    .dbg_starve_cnt(dbg_starve_cnt)
  );

  function automatic logic [DW-1:0] init_val(int a);
    return DW'(a * 7 + 3);
  endfunction

  // SRAM model: unwritten words read as init_val(addr)
  logic [DW-1:0] sram_mem [2**AW];
  bit            sram_wr  [2**AW];
  always @(posedge HCLK) begin
    if (sram_ce) begin
      if (sram_we) begin
        sram_mem[sram_addr] <= sram_wdata;
        sram_wr[sram_addr]  <= 1'b1;
      end else begin
        sram_rdata <= sram_wr[sram_addr] ? sram_mem[sram_addr] : init_val(int'(sram_addr));
      end
    end
  end

  // ---------------- scoreboard / reference model ----------------
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           m_q[$];
  logic [DW-1:0] m_mem [2**AW];
  int            m_starve;
  int            m_owner;   // 0 none, 1 LB, 2 APB
  logic [DW-1:0] m_rsp;
  int            n_total;
  int            n_bad;
  logic          last_wacc, last_lg, last_ag;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_starve = 0;
    m_owner  = 0;
    m_rsp    = '0;
  endtask

  // Called with inputs already driven for this cycle; compares and advances the model.
  task automatic eval_cycle();
    bit            full, starved;
    int            g;  // 0 idle, 1 write, 2 LB, 3 APB
    logic [AW-1:0] ra, ea;
    logic [DW-1:0] rsp;
    wr_t           w;
    #1;
    last_wacc = wr_valid && wr_ready;
    last_lg   = lb_gnt;
    last_ag   = apb_gnt;
    if (HRESET) begin
      model_reset();
      chk("rst_ce", 32'(sram_ce), 0);
      chk("rst_we", 32'(sram_we), 0);
      chk("rst_lb_gnt", 32'(lb_gnt), 0);
      chk("rst_apb_gnt", 32'(apb_gnt), 0);
      chk("rst_addr", 32'(sram_addr), 0);
      chk("rst_wdata", 32'(sram_wdata), 0);
      chk("rst_ready", 32'(wr_ready), 1);
      chk("rst_level", 32'(wfifo_level), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_lb_rvalid", 32'(lb_rvalid), 0);
      chk("rst_apb_rvalid", 32'(apb_rvalid), 0);
      chk("rst_lb_rdata", 32'(lb_rdata), 0);
      chk("rst_apb_rdata", 32'(apb_rdata), 0);
      return;
    end
    full    = (m_q.size() == DEPTH);
    starved = (m_starve == LIMIT) && apb_req;
    if (full)              g = 1;
    else if (starved)      g = 3;
    else if (lb_req)       g = 2;
    else if (m_q.size()>0) g = 1;
    else if (apb_req)      g = 3;
    else                   g = 0;

    chk("lb_gnt", 32'(lb_gnt), 32'(g == 2));
    chk("apb_gnt", 32'(apb_gnt), 32'(g == 3));
    chk("sram_ce", 32'(sram_ce), 32'(g != 0));
    chk("sram_we", 32'(sram_we), 32'(g == 1));
    if (g != 0) begin
      ea = (g == 1) ? m_q[0].addr : (g == 2) ? lb_addr : apb_addr;
      chk("sram_addr", 32'(sram_addr), 32'(ea));
    end
    if (g == 1) chk("sram_wdata", 32'(sram_wdata), 32'(m_q[0].data));
    chk("wr_ready", 32'(wr_ready), 32'(!full));
    chk("level", 32'(wfifo_level), 32'(m_q.size()));
    chk("busy", 32'(busy), 32'((m_q.size() > 0) || (m_owner != 0)));
    chk("lb_rvalid", 32'(lb_rvalid), 32'(m_owner == 1));
    chk("lb_rdata", 32'(lb_rdata), (m_owner == 1) ? 32'(m_rsp) : 0);
    chk("apb_rvalid", 32'(apb_rvalid), 32'(m_owner == 2));
    chk("apb_rdata", 32'(apb_rdata), (m_owner == 2) ? 32'(m_rsp) : 0);
    chk("starve_cnt", 32'(dbg_starve_cnt), 32'(m_starve));

    if (g == 2 || g == 3) begin
      ra  = (g == 2) ? lb_addr : apb_addr;
      rsp = m_mem[ra];
      foreach (m_q[i]) if (m_q[i].addr == ra) rsp = m_q[i].data;
      m_rsp = rsp;
    end
    m_owner = (g == 2) ? 1 : (g == 3) ? 2 : 0;
    if (g == 1) begin
      w = m_q.pop_front();
      m_mem[w.addr] = w.data;
    end
    if (wr_valid && !full) m_q.push_back({wr_addr, wr_data});
    if (apb_req && g != 3) begin
      if (m_starve < LIMIT) m_starve++;
    end else begin
      m_starve = 0;
    end
  endtask

  task automatic next_cycle();
    @(negedge HCLK);
  endtask

  task automatic idle_inputs();
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    lb_req = 1'b0;   lb_addr = '0;
    apb_req = 1'b0;  apb_addr = '0;
  endtask

  task automatic drain(int n);
    idle_inputs();
    for (int i = 0; i < n; i++) begin
      eval_cycle();
      next_cycle();
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int wv, wa, wd, lr, la, ar, aa;
    int e_lg, e_ag, e_ce, e_we, e_lvl, e_busy, e_lrv, e_lrd, e_arv, e_ard, e_st;
  } vec_t;

  vec_t vt[8];

  initial begin
    logic [AW-1:0] ta;
    vt[0] = '{1, 'h010, 'h5A, 0, 0,     0, 0,     0, 0, 0, 0, 0, 0, 0, 0,    0, 0,    0};
    vt[1] = '{1, 'h030, 'h77, 1, 'h010, 0, 0,     1, 0, 1, 0, 1, 1, 0, 0,    0, 0,    0};
    vt[2] = '{0, 0,     0,    0, 0,     0, 0,     0, 0, 1, 1, 2, 1, 1, 'h5A, 0, 0,    0};
    vt[3] = '{0, 0,     0,    1, 'h030, 1, 'h010, 1, 0, 1, 0, 1, 1, 0, 0,    0, 0,    0};
    vt[4] = '{0, 0,     0,    0, 0,     1, 'h010, 0, 0, 1, 1, 1, 1, 1, 'h77, 0, 0,    1};
    vt[5] = '{0, 0,     0,    0, 0,     1, 'h010, 0, 1, 1, 0, 0, 0, 0, 0,    0, 0,    2};
    vt[6] = '{0, 0,     0,    0, 0,     0, 0,     0, 0, 0, 0, 0, 1, 0, 0,    1, 'h5A, 0};
    vt[7] = '{0, 0,     0,    0, 0,     0, 0,     0, 0, 0, 0, 0, 0, 0, 0,    0, 0,    0};

    n_total = 0;
    n_bad   = 0;
    for (int a = 0; a < 2**AW; a++) m_mem[a] = init_val(a);
    model_reset();
    idle_inputs();
    HRESET = 1'b1;
    repeat (2) @(negedge HCLK);
    eval_cycle();
    next_cycle();
    HRESET = 1'b0;

    // forwarding, priority and drain ordering
    for (int i = 0; i < 8; i++) begin
      wr_valid = vt[i].wv[0]; wr_addr = AW'(vt[i].wa); wr_data = DW'(vt[i].wd);
      lb_req   = vt[i].lr[0]; lb_addr = AW'(vt[i].la);
      apb_req  = vt[i].ar[0]; apb_addr = AW'(vt[i].aa);
      eval_cycle();
      chk($sformatf("t%0d_lb_gnt", i), 32'(lb_gnt), vt[i].e_lg);
      chk($sformatf("t%0d_apb_gnt", i), 32'(apb_gnt), vt[i].e_ag);
      chk($sformatf("t%0d_ce", i), 32'(sram_ce), vt[i].e_ce);
      chk($sformatf("t%0d_we", i), 32'(sram_we), vt[i].e_we);
      chk($sformatf("t%0d_level", i), 32'(wfifo_level), vt[i].e_lvl);
      chk($sformatf("t%0d_busy", i), 32'(busy), vt[i].e_busy);
      chk($sformatf("t%0d_lb_rvalid", i), 32'(lb_rvalid), vt[i].e_lrv);
      chk($sformatf("t%0d_lb_rdata", i), 32'(lb_rdata), vt[i].e_lrd);
      chk($sformatf("t%0d_apb_rvalid", i), 32'(apb_rvalid), vt[i].e_arv);
      chk($sformatf("t%0d_apb_rdata", i), 32'(apb_rdata), vt[i].e_ard);
      chk($sformatf("t%0d_starve", i), 32'(dbg_starve_cnt), vt[i].e_st);
      next_cycle();
    end

    // starvation guard with two queued writes to the same address
    for (int k = 1; k <= 10; k++) begin
      wr_valid = (k <= 2);
      wr_addr  = 11'h020;
      wr_data  = (k == 1) ? 8'h11 : 8'h22;
      lb_req   = 1'b1; lb_addr = 11'h040;
      apb_req  = 1'b1; apb_addr = 11'h020;
      eval_cycle();
      if (k <= 8) begin
        chk("starve_lb_gnt", 32'(lb_gnt), 1);
        chk("starve_apb_wait", 32'(apb_gnt), 0);
        chk("starve_cnt_ramp", 32'(dbg_starve_cnt), 32'(k - 1));
      end else if (k == 9) begin
        chk("starve_apb_forced", 32'(apb_gnt), 1);
        chk("starve_lb_blocked", 32'(lb_gnt), 0);
        chk("starve_cnt_limit", 32'(dbg_starve_cnt), LIMIT);
      end else begin
        chk("starve_cnt_clear", 32'(dbg_starve_cnt), 0);
        chk("multi_fwd_valid", 32'(apb_rvalid), 1);
        chk("multi_fwd_data", 32'(apb_rdata), 32'h22);
      end
      next_cycle();
    end
    drain(4);

    // FIFO full while LB holds its request
    for (int c = 1; c <= 7; c++) begin
      wr_valid = (c <= 6);
      wr_addr  = AW'(32'h060 + ((c == 6) ? 5 : c));
      wr_data  = DW'(32'hA0 + ((c == 6) ? 5 : c));
      lb_req   = 1'b1; lb_addr = 11'h070;
      eval_cycle();
      if (c <= 4) begin
        chk("fill_lb_gnt", 32'(lb_gnt), 1);
        chk("fill_level", 32'(wfifo_level), 32'(c - 1));
      end else if (c == 5 || c == 7) begin
        chk("full_level", 32'(wfifo_level), 4);
        chk("full_ready", 32'(wr_ready), 0);
        chk("full_drain_we", 32'(sram_we), 1);
        chk("full_lb_blocked", 32'(lb_gnt), 0);
      end else begin
        chk("after_full_ready", 32'(wr_ready), 1);
        chk("after_full_level", 32'(wfifo_level), 3);
        chk("after_full_lb_gnt", 32'(lb_gnt), 1);
      end
      next_cycle();
    end
    drain(6);

    // reset with three queued writes and an LB response pending
    for (int c = 1; c <= 3; c++) begin
      wr_valid = 1'b1; wr_addr = AW'(32'h080 + c); wr_data = DW'(32'hB0 + c);
      lb_req   = 1'b1; lb_addr = 11'h010;
      eval_cycle();
      next_cycle();
    end
    idle_inputs();
    #1;
    chk("pre_rst_level", 32'(wfifo_level), 3);
    chk("pre_rst_lb_rvalid", 32'(lb_rvalid), 1);
    HRESET = 1'b1;
    eval_cycle();
    chk("mid_rst_ready", 32'(wr_ready), 1);
    chk("mid_rst_level", 32'(wfifo_level), 0);
    chk("mid_rst_lb_rvalid", 32'(lb_rvalid), 0);
    chk("mid_rst_ce", 32'(sram_ce), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    next_cycle();
    HRESET = 1'b0;
    wr_valid = 1'b1; wr_addr = 11'h090; wr_data = 8'hC1;
    lb_req   = 1'b1; lb_addr = 11'h090;
    eval_cycle();
    chk("post_rst_lb_gnt", 32'(lb_gnt), 1);
    next_cycle();
    idle_inputs();
    eval_cycle();
    chk("post_rst_drain", 32'(sram_we), 1);
    chk("post_rst_lb_rdata", 32'(lb_rdata), 32'(init_val('h090)));
    next_cycle();
    drain(2);

    // random traffic; requesters hold until granted or accepted
    last_wacc = 1'b1; last_lg = 1'b1; last_ag = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        idle_inputs();
        HRESET = 1'b1;
      end else begin
        HRESET = 1'b0;
        if (!wr_valid || last_wacc) begin
          wr_valid = ($urandom_range(0, 99) < 60);
          ta = AW'(32'h100 + $urandom_range(0, 7));
          wr_addr = ta;
          wr_data = DW'($urandom);
        end
        if (!lb_req || last_lg) begin
          lb_req  = ($urandom_range(0, 99) < 40);
          lb_addr = AW'(32'h100 + $urandom_range(0, 7));
        end
        if (!apb_req || last_ag) begin
          apb_req  = ($urandom_range(0, 99) < 30);
          apb_addr = AW'(32'h100 + $urandom_range(0, 7));
        end
      end
      eval_cycle();
      next_cycle();
    end
    HRESET = 1'b0;
    drain(6);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
